segment_register_file: RTL and testbench

- Parametrised successor to the single static segment register: a bank of NUM_SEG segment registers (code/data/stack/extra by default) with one write port and one combinational read port.
- Adds a registered segment:offset to physical-address translation stage, and a shadow bank for single-cycle save/restore on interrupt entry/exit.
- Sits between the control unit (loads, save/restore strobes) and the memory address path.

---
 rtl/segment_register_file_pkg.sv | 24 ++
 rtl/segment_register_file_seg_xlat_stage.sv | 72 +++++++
 rtl/segment_register_file.sv | 135 +++++++++++++
 tb/tb_segment_register_file.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_register_file_pkg.sv
// ---------------------------------------------------------------------------
// segment_register_file_pkg
//   Shared segment select codes and default widths for segment_register_file.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package segment_register_file_pkg;

  localparam int c_DEF_DATA_W    = 16;
  localparam int c_DEF_NUM_SEG   = 4;
  localparam int c_DEF_SEL_W     = 2;
  localparam int c_DEF_SEG_SHIFT = 4;
  localparam int c_DEF_PADDR_W   = 20;

  localparam logic [c_DEF_SEL_W-1:0] SEG_CS = 2'd0;
  localparam logic [c_DEF_SEL_W-1:0] SEG_DS = 2'd1;
  localparam logic [c_DEF_SEL_W-1:0] SEG_SS = 2'd2;
  localparam logic [c_DEF_SEL_W-1:0] SEG_ES = 2'd3;

endpackage

`default_nettype wire

// File: rtl/segment_register_file_seg_xlat_stage.sv
// ---------------------------------------------------------------------------
// seg_xlat_stage
//   Registered segment:offset to physical address stage (base<<SHIFT + offset).
//   SEG_LIMIT_CHECK_EN adds a registered offset-over-limit fault flag.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module seg_xlat_stage
  import segment_register_file_pkg::*;
#(
  parameter int DATA_W    = c_DEF_DATA_W,
  parameter int SEG_SHIFT = c_DEF_SEG_SHIFT,
  parameter int PADDR_W   = c_DEF_PADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               xlat_valid,
  input  logic [DATA_W-1:0]  xlat_base,
  input  logic [DATA_W-1:0]  xlat_offset,
`ifdef SEG_LIMIT_CHECK_EN
  input  logic [DATA_W-1:0]  xlat_limit,
  output logic               xlat_fault,
`endif
  output logic               xlat_out_valid,
  output logic [PADDR_W-1:0] xlat_paddr
);

  // Sum is formed at least PADDR_W wide, then truncated so overflow wraps.
  localparam int c_SUM_W = (DATA_W + SEG_SHIFT > PADDR_W) ? (DATA_W + SEG_SHIFT) : PADDR_W;

  logic [c_SUM_W-1:0] w_shifted;
  logic [c_SUM_W-1:0] w_sum;
  logic               r_valid;
  logic [PADDR_W-1:0] r_paddr;

  assign w_shifted = c_SUM_W'(xlat_base) << SEG_SHIFT;
  assign w_sum     = w_shifted + c_SUM_W'(xlat_offset);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_paddr <= '0;
    end else begin
      r_valid <= xlat_valid;
      if (xlat_valid) begin
        r_paddr <= w_sum[PADDR_W-1:0];
      end
    end
  end

  assign xlat_out_valid = r_valid;
  assign xlat_paddr     = r_paddr;

`ifdef SEG_LIMIT_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= xlat_valid & (xlat_offset > xlat_limit);
    end
  end

  assign xlat_fault = r_fault;
`endif

endmodule

`default_nettype wire

// File: rtl/segment_register_file.sv
// ---------------------------------------------------------------------------
// segment_register_file
//   Bank of segment registers with shadow save/restore and a registered
//   address translation stage. SEG_LIMIT_CHECK_EN adds per-segment limits.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module segment_register_file
  import segment_register_file_pkg::*;
#(
  parameter int DATA_W    = c_DEF_DATA_W,
  parameter int NUM_SEG   = c_DEF_NUM_SEG,
  parameter int SEL_W     = c_DEF_SEL_W,
  parameter int SEG_SHIFT = c_DEF_SEG_SHIFT,
  parameter int PADDR_W   = c_DEF_PADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_seg,
  input  logic [SEL_W-1:0]   seg_wr_sel,
  input  logic [DATA_W-1:0]  seg_data_in,
  input  logic [SEL_W-1:0]   seg_rd_sel,
  output logic [DATA_W-1:0]  seg_data_out,
  input  logic               save_segs,
  input  logic               restore_segs,
`ifdef SEG_LIMIT_CHECK_EN
  input  logic               load_limit,
  output logic               xlat_fault,
`endif
  input  logic               xlat_valid,
  input  logic [SEL_W-1:0]   xlat_seg,
  input  logic [DATA_W-1:0]  xlat_offset,
  output logic               xlat_out_valid,
  output logic [PADDR_W-1:0] xlat_paddr
);

  logic [DATA_W-1:0] r_active [NUM_SEG];
  logic [DATA_W-1:0] r_shadow [NUM_SEG];
  logic [DATA_W-1:0] w_xlat_base;

  // Save reads pre-edge active values, so save+restore is a true swap and
  // a concurrent load never lands in the shadow bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (load_seg && (seg_wr_sel == SEL_W'(i))) begin
          r_active[i] <= seg_data_in;
        end else if (restore_segs) begin
          r_active[i] <= r_shadow[i];
        end
        if (save_segs) begin
          r_shadow[i] <= r_active[i];
        end
      end
    end
  end

`ifdef SEG_LIMIT_CHECK_EN
  logic [DATA_W-1:0] r_limit        [NUM_SEG];
  logic [DATA_W-1:0] r_limit_shadow [NUM_SEG];
  logic [DATA_W-1:0] w_xlat_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        r_limit[i]        <= '1;
        r_limit_shadow[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (load_limit && (seg_wr_sel == SEL_W'(i))) begin
          r_limit[i] <= seg_data_in;
        end else if (restore_segs) begin
          r_limit[i] <= r_limit_shadow[i];
        end
        if (save_segs) begin
          r_limit_shadow[i] <= r_limit[i];
        end
      end
    end
  end

  // Out-of-range selects see an all-ones limit and therefore never fault.
  always_comb begin
    w_xlat_limit = '1;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (xlat_seg == SEL_W'(i)) begin
        w_xlat_limit = r_limit[i];
      end
    end
  end
`endif

  // Out-of-range selects read as zero on both the read port and the base.
  always_comb begin
    seg_data_out = '0;
    w_xlat_base  = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (seg_rd_sel == SEL_W'(i)) begin
        seg_data_out = r_active[i];
      end
      if (xlat_seg == SEL_W'(i)) begin
        w_xlat_base = r_active[i];
      end
    end
  end

  seg_xlat_stage #(
    .DATA_W    (DATA_W),
    .SEG_SHIFT (SEG_SHIFT),
    .PADDR_W   (PADDR_W)
  ) u_xlat (
    .clk            (clk),
    .reset          (reset),
    .xlat_valid     (xlat_valid),
    .xlat_base      (w_xlat_base),
    .xlat_offset    (xlat_offset),
`ifdef SEG_LIMIT_CHECK_EN
    .xlat_limit     (w_xlat_limit),
    .xlat_fault     (xlat_fault),
`endif
    .xlat_out_valid (xlat_out_valid),
    .xlat_paddr     (xlat_paddr)
  );

endmodule

`default_nettype wire

// File: tb/tb_segment_register_file.sv
// ---------------------------------------------------------------------------
// tb_segment_register_file
//   Scoreboard bench for segment_register_file (NUM_SEG=4, SEL_W=3).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_segment_register_file;

  localparam int DATA_W    = 16;
  localparam int NUM_SEG   = 4;
  localparam int SEL_W     = 3;
  localparam int SEG_SHIFT = 4;
  localparam int PADDR_W   = 20;

  localparam logic [2:0] c_CS = 3'd0;
  localparam logic [2:0] c_DS = 3'd1;
  localparam logic [2:0] c_ES = 3'd3;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_seg;
  logic [SEL_W-1:0]   seg_wr_sel;
  logic [DATA_W-1:0]  seg_data_in;
  logic [SEL_W-1:0]   seg_rd_sel;
  logic [DATA_W-1:0]  seg_data_out;
  logic               save_segs;
  logic               restore_segs;
  logic               load_limit;
  logic               xlat_fault;
  logic               xlat_valid;
  logic [SEL_W-1:0]   xlat_seg;
  logic [DATA_W-1:0]  xlat_offset;
  logic               xlat_out_valid;
  logic [PADDR_W-1:0] xlat_paddr;

  segment_register_file #(
    .DATA_W    (DATA_W),
    .NUM_SEG   (NUM_SEG),
    .SEL_W     (SEL_W),
    .SEG_SHIFT (SEG_SHIFT),
    .PADDR_W   (PADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_seg       (load_seg),
    .seg_wr_sel     (seg_wr_sel),
    .seg_data_in    (seg_data_in),
    .seg_rd_sel     (seg_rd_sel),
    .seg_data_out   (seg_data_out),
    .save_segs      (save_segs),
    .restore_segs   (restore_segs),
`ifdef SEG_LIMIT_CHECK_EN
    .load_limit     (load_limit),
    .xlat_fault     (xlat_fault),
`endif
    .xlat_valid     (xlat_valid),
    .xlat_seg       (xlat_seg),
    .xlat_offset    (xlat_offset),
    .xlat_out_valid (xlat_out_valid),
    .xlat_paddr     (xlat_paddr)
  );

`ifndef SEG_LIMIT_CHECK_EN
  assign xlat_fault = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] paddr;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_active [4];
  logic [15:0] m_shadow [4];
  logic [15:0] m_limit  [4];
  logic [15:0] m_lshadow[4];
  logic [19:0] m_paddr;
  logic        m_fault;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] seg_model(input logic [2:0] sel);
    logic [1:0] idx;
    idx = sel[1:0];
    if (sel < 3'd4) return m_active[idx];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] limit_model(input logic [2:0] sel);
    logic [1:0] idx;
    idx = sel[1:0];
    if (sel < 3'd4) return m_limit[idx];
    return 16'hFFFF;
  endfunction

  function automatic logic [19:0] xlat_model(input logic [15:0] base, input logic [15:0] off);
    logic [31:0] s;
    s = ({16'h0, base} * 32'd16) + {16'h0, off};
    return s[19:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_active[i]  = 16'h0;
      m_shadow[i]  = 16'h0;
      m_limit[i]   = 16'hFFFF;
      m_lshadow[i] = 16'hFFFF;
    end
    m_paddr = 20'h0;
    m_fault = 1'b0;
    sb.delete();
  endtask

  task automatic clear_strobes();
    load_seg     = 1'b0;
    load_limit   = 1'b0;
    save_segs    = 1'b0;
    restore_segs = 1'b0;
    xlat_valid   = 1'b0;
  endtask

  // Advance one edge: push expected translation, update model, check outputs.
  task automatic step();
    logic [15:0] na[4], ns[4], nl[4], nls[4];
    logic        ev;
    exp_t        e;
    ev = xlat_valid;
    if (xlat_valid) begin
      e.paddr = xlat_model(seg_model(xlat_seg), xlat_offset);
`ifdef SEG_LIMIT_CHECK_EN
      e.fault = (xlat_offset > limit_model(xlat_seg));
`else
      e.fault = 1'b0;
`endif
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      na[i] = m_active[i];  ns[i] = m_shadow[i];
      nl[i] = m_limit[i];   nls[i] = m_lshadow[i];
      if (save_segs) begin
        ns[i] = m_active[i];
        nls[i] = m_limit[i];
      end
      if (restore_segs) begin
        na[i] = m_shadow[i];
        nl[i] = m_lshadow[i];
      end
      if (load_seg && seg_wr_sel == 3'(i)) na[i] = seg_data_in;
`ifdef SEG_LIMIT_CHECK_EN
      if (load_limit && seg_wr_sel == 3'(i)) nl[i] = seg_data_in;
`endif
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_active[i] = na[i];  m_shadow[i] = ns[i];
      m_limit[i]  = nl[i];  m_lshadow[i] = nls[i];
    end
    clear_strobes();
    check("xlat_out_valid", 32'(xlat_out_valid), 32'(ev));
    if (ev) begin
      e = sb.pop_front();
      m_paddr = e.paddr;
      m_fault = e.fault;
    end else begin
      m_fault = 1'b0;
    end
    check("xlat_paddr", 32'(xlat_paddr), 32'(m_paddr));
`ifdef SEG_LIMIT_CHECK_EN
    check("xlat_fault", 32'(xlat_fault), 32'(m_fault));
`endif
  endtask

  task automatic check_rd(input logic [2:0] sel);
    seg_rd_sel = sel;
    #1;
    check($sformatf("read_sel%0d", sel), 32'(seg_data_out), 32'(seg_model(sel)));
  endtask

  task automatic drive_load(input logic [2:0] sel, input logic [15:0] data);
    load_seg    = 1'b1;
    seg_wr_sel  = sel;
    seg_data_in = data;
  endtask

  task automatic drive_xlat(input logic [2:0] sel, input logic [15:0] off);
    xlat_valid  = 1'b1;
    xlat_seg    = sel;
    xlat_offset = off;
  endtask

  initial begin
    reset = 1'b1;
    clear_strobes();
    seg_wr_sel = '0; seg_data_in = '0; seg_rd_sel = '0;
    xlat_seg = '0; xlat_offset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 5; s++) check_rd(3'(s));
    check("reset_valid", 32'(xlat_out_valid), 32'd0);
    check("reset_paddr", 32'(xlat_paddr), 32'd0);
    #1 reset = 1'b0;

    // Consecutive loads to DS
    drive_load(c_DS, 16'h2000); step();
    seg_rd_sel = c_DS; #1 check("ds_first", 32'(seg_data_out), 32'h2000);
    drive_load(c_DS, 16'h3500); step();
    seg_rd_sel = c_DS; #1 check("ds_second", 32'(seg_data_out), 32'h3500);
    seg_rd_sel = c_CS; #1 check("cs_untouched", 32'(seg_data_out), 32'h0000);

    // Translation, wrap, same-edge load
    drive_load(c_DS, 16'h1234); step();
    drive_xlat(c_DS, 16'h0010); step();
    check("xlat_ds", 32'(xlat_paddr), 32'h12350);
    drive_load(c_ES, 16'hFFFF); step();
    drive_xlat(c_ES, 16'h0010); step();
    check("xlat_wrap", 32'(xlat_paddr), 32'h00000);
    drive_load(c_DS, 16'h5000); drive_xlat(c_DS, 16'h0001); step();
    check("xlat_old_base", 32'(xlat_paddr), 32'h12341);
    check_rd(c_DS);
    drive_xlat(c_DS, 16'h0002); step();
    drive_xlat(c_CS, 16'h0003); step();
    step();

    // Save / restore / swap / load-with-restore
    drive_load(c_CS, 16'h1000); step();
    save_segs = 1'b1; step();
    drive_load(c_CS, 16'h2000); step();
    restore_segs = 1'b1; step();
    seg_rd_sel = c_CS; #1 check("cs_restored", 32'(seg_data_out), 32'h1000);
    drive_load(c_CS, 16'hAAAA); step();
    save_segs = 1'b1; restore_segs = 1'b1; step();
    seg_rd_sel = c_CS; #1 check("cs_swapped", 32'(seg_data_out), 32'h1000);
    restore_segs = 1'b1; step();
    seg_rd_sel = c_CS; #1 check("shadow_swapped", 32'(seg_data_out), 32'hAAAA);
    drive_load(c_DS, 16'h0BAD); step();
    drive_load(c_CS, 16'h7777); restore_segs = 1'b1; step();
    seg_rd_sel = c_CS; #1 check("cs_load_restore", 32'(seg_data_out), 32'h7777);
    for (int s = 1; s < 4; s++) check_rd(3'(s));

    // Out-of-range select
    drive_load(3'd5, 16'hBEEF); step();
    for (int s = 0; s < 6; s++) check_rd(3'(s));
    drive_xlat(3'd5, 16'h0ABC); step();
    check("xlat_oor", 32'(xlat_paddr), 32'h00ABC);

`ifdef SEG_LIMIT_CHECK_EN
    load_limit = 1'b1; seg_wr_sel = c_DS; seg_data_in = 16'h00FF; step();
    drive_xlat(c_DS, 16'h0100); step();
    check("fault_over", 32'(xlat_fault), 32'd1);
    drive_xlat(c_DS, 16'h00FF); step();
    check("fault_at_limit", 32'(xlat_fault), 32'd0);
    drive_load(c_DS, 16'h4444); load_limit = 1'b1; seg_data_in = 16'h0010; step();
    drive_xlat(c_DS, 16'h0011); step();
`endif

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      load_seg     = ($urandom_range(0, 2) == 0);
      load_limit   = ($urandom_range(0, 3) == 0);
      seg_wr_sel   = 3'($urandom_range(0, 5));
      seg_data_in  = 16'($urandom);
      save_segs    = ($urandom_range(0, 3) == 0);
      restore_segs = ($urandom_range(0, 3) == 0);
      xlat_valid   = ($urandom_range(0, 1) == 1);
      xlat_seg     = 3'($urandom_range(0, 5));
      xlat_offset  = 16'($urandom);
      step();
      check_rd(3'($urandom_range(0, 5)));
    end

    // Reset during a valid translation
    drive_load(c_SS_sel(), 16'h9999); step();
    drive_xlat(3'd2, 16'h0042); step();
    drive_xlat(3'd2, 16'h0043);
    seg_rd_sel = 3'd2;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(xlat_out_valid), 32'd0);
    check("rst_paddr", 32'(xlat_paddr), 32'd0);
    check("rst_read", 32'(seg_data_out), 32'd0);
    clear_strobes();
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    step();
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic [2:0] c_SS_sel();
    return 3'd2;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
